// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and width helper for the FIFO write arbiter
//
// Purpose: arbiter state encoding and a width helper that never returns 0,
//          so single-entry parameters still yield a legal vector width.
// Ports:   none (package).

package fifo_arb_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      XFER = 1'b1
   } arb_state_e;

   // Bits needed to index n distinct values; at least 1.
   function automatic int width_of(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
//
// Purpose: returns the first asserted request at or above ptr_i, wrapping
//          modulo NREQ (also for non-power-of-two NREQ).
// Ports:
//   req_i  in  NREQ  request vector
//   ptr_i  in  PW    search start position
//   gnt_o  out NREQ  one-hot pick, 0 when no request is set

module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int PW   = width_of(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [PW-1:0]   ptr_i,
   output logic [NREQ-1:0] gnt_o
);

   logic          found;
   logic [PW-1:0] idx;

   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = PW'((int'(ptr_i) + k) % NREQ);
         if (!found && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - packet-locked round-robin arbiter for the FIFO write port
//
// Purpose: shares one FIFO write port between NREQ valid/ready beat streams.
//          An owner keeps the port until its last beat or MAXBEAT beats.
//          A one-entry output register feeds the FIFO and obeys wfull.
// Ports:
//   clk        in  1         write-side clock
//   rst_n      in  1         asynchronous active-low reset
//   req_valid  in  NREQ      per-requester beat valid
//   req_data   in  NREQ*WID  beat data, requester i at [i*WID +: WID]
//   req_last   in  NREQ      final beat of a packet
//   req_ready  out NREQ      beat accepted when valid & ready
//   grant      out NREQ      one-hot current owner, 0 when idle
//   wfull      in  1         FIFO full
//   writex     out 1         FIFO write strobe
//   wdata      out WID       FIFO write data
//   pkt_err    out 1         sticky: a grant was force-released at MAXBEAT

module fifo_wr_arb
   import fifo_arb_pkg::*;
#(
   parameter int WID     = 32,
   parameter int NREQ    = 4,
   parameter int MAXBEAT = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [NREQ*WID-1:0] req_data,
   input  logic [NREQ-1:0]     req_last,
   output logic [NREQ-1:0]     req_ready,
   output logic [NREQ-1:0]     grant,
   input  logic                wfull,
   output logic                writex,
   output logic [WID-1:0]      wdata,
   output logic                pkt_err
);

   localparam int PW = width_of(NREQ);
   localparam int CW = width_of(MAXBEAT + 1);

   arb_state_e      state_q, state_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            out_vld_q, out_vld_d;
   logic [WID-1:0]  out_data_q, out_data_d;
   logic            err_q, err_d;

   logic [NREQ-1:0] pick;
   logic [PW-1:0]   owner_idx;
   logic [WID-1:0]  owner_data;
   logic            owner_last;
   logic            owner_valid;
   logic            can_load;
   logic            accept;
   logic [CW-1:0]   cnt_inc;
   logic            at_limit;

   rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_pick (
      .req_i (req_valid),
      .ptr_i (ptr_q),
      .gnt_o (pick)
   );

   // Route the owner's stream through a one-hot mux; grant_q is 0 in IDLE.
   always_comb begin
      owner_idx   = '0;
      owner_data  = '0;
      owner_last  = 1'b0;
      owner_valid = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_q[i]) begin
            owner_idx   = PW'(i);
            owner_data  = req_data[i*WID +: WID];
            owner_last  = req_last[i];
            owner_valid = req_valid[i];
         end
      end
   end

   // The register may take a beat when empty or when it drains this cycle,
   // which gives a simultaneous load and write as wfull falls.
   assign can_load  = ~out_vld_q | ~wfull;
   assign req_ready = (state_q == XFER) ? (grant_q & {NREQ{can_load}}) : '0;
   assign accept    = (state_q == XFER) & can_load & owner_valid;
   assign writex    = out_vld_q & ~wfull;
   assign wdata     = out_data_q;
   assign grant     = grant_q;
   assign pkt_err   = err_q;
   assign cnt_inc   = cnt_q + CW'(1);
   assign at_limit  = (cnt_inc == CW'(MAXBEAT));

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      out_vld_d  = out_vld_q;
      out_data_d = out_data_q;

      if (writex) begin
         out_vld_d = 1'b0;
      end
      if (accept) begin
         out_vld_d  = 1'b1;
         out_data_d = owner_data;
      end

      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               grant_d = pick;
               state_d = XFER;
            end
         end
         XFER: begin
            if (accept) begin
               cnt_d = cnt_inc;
               if (owner_last || at_limit) begin
                  state_d = IDLE;
                  grant_d = '0;
                  cnt_d   = '0;
                  ptr_d   = (owner_idx == PW'(NREQ - 1)) ? '0 : owner_idx + PW'(1);
                  if (!owner_last) begin
                     err_d = 1'b1;
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         ptr_q      <= '0;
         cnt_q      <= '0;
         out_vld_q  <= 1'b0;
         out_data_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         out_vld_q  <= out_vld_d;
         out_data_q <= out_data_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb/tb_fifo_wr_arb.sv - self-checking bench for fifo_wr_arb

module tb_fifo_wr_arb;

   localparam int WID     = 32;
   localparam int NREQ    = 4;
   localparam int MAXBEAT = 16;

   logic                clk;
   logic                rst_n;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ*WID-1:0] req_data;
   logic [NREQ-1:0]     req_last;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ-1:0]     grant;
   logic                wfull;
   logic                writex;
   logic [WID-1:0]      wdata;
   logic                pkt_err;

   fifo_wr_arb #(
      .WID     (WID),
      .NREQ    (NREQ),
      .MAXBEAT (MAXBEAT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .grant     (grant),
      .wfull     (wfull),
      .writex    (writex),
      .wdata     (wdata),
      .pkt_err   (pkt_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // per-requester beat sources: {last, data}
   logic [WID:0]    srcq [NREQ][$];
   logic [NREQ-1:0] stall;

   // observed FIFO writes and grant starts
   logic [WID-1:0]  wr_log [$];
   int              wr_cyc [$];
   int              gnt_log [$];
   int              gnt_cyc [$];
   logic [NREQ-1:0] prev_grant;

   // behavioural model: owner index (-1 idle), pointer, beat count, held beat
   int             m_owner, m_ptr, m_cnt;
   bit             m_held, m_err;
   logic [WID-1:0] m_data;
   int             n_owner, n_ptr, n_cnt;
   bit             n_held, n_err;
   logic [WID-1:0] n_data;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_held = 0; m_err = 0; m_data = '0;
      n_owner = -1; n_ptr = 0; n_cnt = 0; n_held = 0; n_err = 0; n_data = '0;
   endtask

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst_n) begin
         m_owner = n_owner; m_ptr = n_ptr; m_cnt = n_cnt;
         m_held  = n_held;  m_err = n_err; m_data = n_data;
      end
   end

   // compare process: expected outputs from the arbitration rules each cycle
   always @(negedge clk) begin
      logic [NREQ-1:0] e_grant, e_ready;
      logic            e_writex;
      bit              can;
      e_grant  = '0;
      e_ready  = '0;
      e_writex = 1'b0;
      if (!rst_n) begin
         model_reset();
         prev_grant = '0;
      end else begin
         can      = !m_held || !wfull;
         e_writex = m_held && !wfull;
         n_owner = m_owner; n_ptr = m_ptr; n_cnt = m_cnt; n_err = m_err;
         n_data  = m_data;
         n_held  = e_writex ? 1'b0 : m_held;
         if (m_owner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
               int j;
               j = (m_ptr + k) % NREQ;
               if (n_owner < 0 && req_valid[j]) n_owner = j;
            end
         end else begin
            e_grant[m_owner] = 1'b1;
            if (can) e_ready[m_owner] = 1'b1;
            if (can && req_valid[m_owner]) begin
               n_held = 1'b1;
               n_data = req_data[m_owner*WID +: WID];
               n_cnt  = m_cnt + 1;
               if (req_last[m_owner] || n_cnt == MAXBEAT) begin
                  if (!req_last[m_owner]) n_err = 1'b1;
                  n_ptr   = (m_owner + 1) % NREQ;
                  n_owner = -1;
                  n_cnt   = 0;
               end
            end
         end
         if (writex) begin
            wr_log.push_back(wdata);
            wr_cyc.push_back(cyc);
         end
         if (grant != '0 && prev_grant == '0) begin
            for (int i = 0; i < NREQ; i++) if (grant[i]) gnt_log.push_back(i);
            gnt_cyc.push_back(cyc);
         end
         prev_grant = grant;
      end
      chk("grant", 64'(grant), 64'(e_grant));
      chk("req_ready", 64'(req_ready), 64'(e_ready));
      chk("writex", 64'(writex), 64'(e_writex));
      chk("wdata", 64'(wdata), 64'(rst_n ? m_data : '0));
      chk("pkt_err", 64'(pkt_err), 64'(rst_n ? m_err : 1'b0));
   end

   task automatic drive();
      logic [WID:0] ent;
      for (int i = 0; i < NREQ; i++) begin
         if (srcq[i].size() > 0 && !stall[i]) begin
            ent = srcq[i][0];
            req_valid[i]              = 1'b1;
            req_data[i*WID +: WID]    = ent[WID-1:0];
            req_last[i]               = ent[WID];
         end else begin
            req_valid[i]              = 1'b0;
            req_data[i*WID +: WID]    = '0;
            req_last[i]               = 1'b0;
         end
      end
   endtask

   task automatic step();
      logic [NREQ-1:0] acc;
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) if (acc[i]) void'(srcq[i].pop_front());
      drive();
   endtask

   task automatic push(input int r, input logic [WID-1:0] d, input bit last);
      srcq[r].push_back({last, d});
   endtask

   task automatic clear_logs();
      wr_log.delete(); wr_cyc.delete(); gnt_log.delete(); gnt_cyc.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      wfull = 1'b0;
      stall = '0;
      for (int i = 0; i < NREQ; i++) srcq[i].delete();
      drive();
      #1;
      chk("rst_grant", 64'(grant), 64'h0);
      chk("rst_ready", 64'(req_ready), 64'h0);
      chk("rst_writex", 64'(writex), 64'h0);
      chk("rst_wdata", 64'(wdata), 64'h0);
      chk("rst_pkt_err", 64'(pkt_err), 64'h0);
      step();
      rst_n = 1'b1;
      clear_logs();
   endtask

   task automatic run_idle(input string nm);
      int n;
      n = 0;
      while ((srcq[0].size() + srcq[1].size() + srcq[2].size() + srcq[3].size() != 0
              || m_held) && n < 400) begin
         step();
         n++;
      end
      total++;
      if (n >= 400) begin
         bad++;
         $display("FAIL %s_timeout actual=%0d required<400 cycles", nm, n);
      end
      repeat (2) step();
   endtask

   initial begin
      int c0;
      int nw;
      rst_n     = 1'b0;
      wfull     = 1'b0;
      stall     = '0;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      @(posedge clk);
      #1;
      do_reset();

      // single requester: 3 beats
      c0 = cyc;
      push(0, 32'hA0, 0); push(0, 32'hA1, 0); push(0, 32'hA2, 1);
      drive();
      step();
      chk("t1_grant_c1", 64'(grant), 64'b0001);
      chk("t1_ready_c1", 64'(req_ready), 64'b0001);
      repeat (3) step();
      chk("t1_grant_c4", 64'(grant), 64'b0000);
      run_idle("t1");
      chk("t1_nwrites", wr_log.size(), 3);
      for (int i = 0; i < 3; i++) begin
         chk("t1_wdata", 64'(wr_log[i]), 64'(32'hA0 + i));
         chk("t1_wcycle", 64'(wr_cyc[i] - c0), 64'(2 + i));
      end

      // fairness: two 1-beat packets per requester
      do_reset();
      for (int k = 0; k < 2; k++)
         for (int r = 0; r < NREQ; r++) push(r, 32'h100 * r + k, 1);
      drive();
      run_idle("t2");
      chk("t2_ngrants", gnt_log.size(), 8);
      for (int i = 0; i < 8; i++) begin
         chk("t2_order", 64'(gnt_log[i]), 64'(i % 4));
         if (i > 0) chk("t2_gap", 64'(gnt_cyc[i] - gnt_cyc[i-1]), 64'd2);
         chk("t2_wdata", 64'(wr_log[i]), 64'(32'h100 * (i % 4) + i / 4));
      end

      // backpressure: wfull high 5 cycles mid-packet
      do_reset();
      for (int k = 0; k < 8; k++) push(0, 32'hB0 + k, k == 7);
      drive();
      repeat (4) step();
      wfull = 1'b1;
      nw = wr_log.size();
      chk("t3_pre_writes", nw, 2);
      repeat (5) step();
      chk("t3_full_writes", wr_log.size(), nw);
      wfull = 1'b0;
      run_idle("t3");
      chk("t3_nwrites", wr_log.size(), 8);
      for (int i = 0; i < 8; i++) chk("t3_wdata", 64'(wr_log[i]), 64'(32'hB0 + i));

      // beat limit: req2 sends 20 beats with no last, req3 waiting
      do_reset();
      for (int k = 0; k < 20; k++) push(2, 32'h2000 + k, 0);
      push(3, 32'h3000, 1);
      drive();
      run_idle("t4");
      chk("t4_pkt_err", 64'(pkt_err), 64'd1);
      chk("t4_ngrants", gnt_log.size(), 3);
      chk("t4_g0", 64'(gnt_log[0]), 64'd2);
      chk("t4_g1", 64'(gnt_log[1]), 64'd3);
      chk("t4_g2", 64'(gnt_log[2]), 64'd2);
      chk("t4_grant_held", 64'(grant), 64'b0100);
      chk("t4_nwrites", wr_log.size(), 21);
      chk("t4_w15", 64'(wr_log[15]), 64'h200F);
      chk("t4_w16", 64'(wr_log[16]), 64'h3000);
      chk("t4_w17", 64'(wr_log[17]), 64'h2010);

      // owner stall: req1 drops valid for 3 cycles while req0 waits
      do_reset();
      for (int k = 0; k < 5; k++) push(1, 32'h1100 + k, k == 4);
      drive();
      step();
      push(0, 32'h1000, 0); push(0, 32'h1001, 1);
      drive();
      repeat (2) step();
      stall[1] = 1'b1;
      drive();
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t5_grant_stall", 64'(grant), 64'b0010);
         chk("t5_ready0", 64'(req_ready[0]), 64'd0);
      end
      stall[1] = 1'b0;
      drive();
      run_idle("t5");
      chk("t5_ngrants", gnt_log.size(), 2);
      chk("t5_g0", 64'(gnt_log[0]), 64'd1);
      chk("t5_g1", 64'(gnt_log[1]), 64'd0);
      chk("t5_nwrites", wr_log.size(), 7);
      chk("t5_w4", 64'(wr_log[4]), 64'h1104);
      chk("t5_w5", 64'(wr_log[5]), 64'h1000);

      // reset mid-packet during beat 2
      do_reset();
      for (int k = 0; k < 4; k++) push(1, 32'h4000 + k, k == 3);
      drive();
      repeat (2) step();
      chk("t6_pre_grant", 64'(grant), 64'b0010);
      rst_n = 1'b0;
      #1;
      chk("t6_writex_now", 64'(writex), 64'd0);
      chk("t6_grant_now", 64'(grant), 64'd0);
      chk("t6_ready_now", 64'(req_ready), 64'd0);
      for (int i = 0; i < NREQ; i++) srcq[i].delete();
      drive();
      step();
      rst_n = 1'b1;
      clear_logs();
      push(3, 32'h5300, 1);
      push(0, 32'h5000, 1);
      drive();
      run_idle("t6");
      chk("t6_first_grant", 64'(gnt_log[0]), 64'd0);
      chk("t6_second_grant", 64'(gnt_log[1]), 64'd3);
      chk("t6_nwrites", wr_log.size(), 2);
      chk("t6_w0", 64'(wr_log[0]), 64'h5000);
      chk("t6_w1", 64'(wr_log[1]), 64'h5300);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Packet-locked round-robin arbiter that shares the write port of the `async2fifo` block between `NREQ` requesters, all in the write-clock domain. Each requester offers a valid/ready beat stream with a `last` marker. Once granted, a requester keeps the FIFO until its packet ends or a beat limit is hit. A one-entry output register drives `writex`/`wdata` and honours `wfull` backpressure, so the FIFO never sees a write while full.

## Interface
- `WID`, 32, beat data width; equals the FIFO `WID`
- `NREQ`, 4, number of requesters, 2..8
- `MAXBEAT`, 16, maximum beats per grant; the grant is force-released at this count
- `clk`  in  1  write-side clock, same as the FIFO `wclk`
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  NREQ  per-requester beat valid
- `req_data`  in  NREQ*WID  beat data; requester i occupies bits [i*WID +: WID]
- `req_last`  in  NREQ  marks the final beat of a packet
- `req_ready`  out  NREQ  per-requester beat accepted when `valid & ready`
- `grant`  out  NREQ  one-hot current owner; 0 when idle
- `wfull`  in  1  FIFO full, from `async2fifo`
- `writex`  out  1  FIFO write strobe
- `wdata`  out  WID  FIFO write data
- `pkt_err`  out  1  sticky; set when a grant is force-released at `MAXBEAT`

## Operation
- Reset values: `grant`=0, `req_ready`=0, `writex`=0, `wdata`=0, `pkt_err`=0, state=IDLE, RR pointer=0, beat count=0, `out_vld`=0.
- States:
  - IDLE: if any `req_valid`, select the first set bit searching from the RR pointer upward with wrap. Register `grant` to that one-hot value. Go to XFER. Otherwise stay in IDLE.
  - XFER: `req_ready[i] = grant[i] & (~out_vld | ~wfull)`. Each accepted beat loads the output register and increments the beat count.
  - XFER exit: an accepted beat with `req_last=1`, or an accepted beat that makes count == `MAXBEAT`, returns to IDLE.
  - On exit: clear `grant`, set the RR pointer to owner+1 (mod NREQ), and clear the count.
- A `MAXBEAT` exit without `last` sets `pkt_err`. The bit stays set until reset.
- Output stage:
  - `writex = out_vld & ~wfull`, combinational.
  - `wdata` = output register.
  - `out_vld` clears on `writex` unless a new beat loads in the same cycle.
- Non-owners always see `req_ready`=0.
- The owner deasserting `req_valid` mid-packet is legal: grant is held and no beats are accepted.
- Requester `valid`/`data`/`last` must stay stable until ready; the block does not check this.
- Beat count width is `$clog2(MAXBEAT+1)`. RR pointer width is `$clog2(NREQ)`. Pointer wrap is modulo NREQ, including non-power-of-two NREQ.

## Timing
- `req_valid` rises in IDLE → `grant` at the next edge (+1 cycle).
- `req_ready` is high in that same cycle if there is no backpressure. `writex` for that beat follows at +2 cycles.
- Steady state: one beat per clock while `wfull`=0.
- Exactly one idle bubble cycle between packets: the IDLE arbitration cycle.
- `wfull` rising with `out_vld`=1:
  - `writex` drops in the same cycle, the beat is held in the register, and owner `req_ready` drops.
  - No beat is lost or duplicated.
- `wfull` falling: the held beat is written that cycle, and `req_ready` is high the same cycle (simultaneous load and write).
- Asynchronous `rst_n` mid-packet: all outputs clear immediately. Any held or partial beat is discarded. The FIFO is reset alongside.

## Structure
- Package `fifo_arb_pkg`: state enum (IDLE, XFER) and a `clog2`-based width helper.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `NREQ` request vector and the pointer.
  - Output: one-hot grant.
  - Instantiated once.

## Test plan
- Single requester: req0 sends 3 beats `0xA0..0xA2` with last on `0xA2`, `wfull`=0 → `writex` on cycles 2, 3, 4 after valid; `wdata` = `A0, A1, A2`; `grant`=`0001` then 0.
- Fairness: all 4 requesters continuously send 1-beat packets → grant order 0, 1, 2, 3, 0, …; one idle cycle between grants.
- Backpressure: `wfull` forced high for 5 cycles mid-packet → `writex`=0 throughout; data resumes in order with no loss or duplication; FIFO contents match the sent sequence.
- Beat limit: req2 sends 20 beats with no last → release after beat 16; `pkt_err`=1; the next grant goes to req3 if it is valid.
- Owner stall: req1 drops valid for 3 cycles mid-packet while req0 is valid → `grant` stays `0010`; req0 waits until req1's last beat.
- Reset mid-packet: `rst_n` low for 1 cycle during beat 2 → `writex`, `grant` and `req_ready` are 0 immediately; the first grant after reset goes to req0.
